// File: rtl/mealy_1001_overlapping_pkg.sv
// Shared types and constants for the overlapping "1001" Mealy detector.
package mealy_1001_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,   // idle
        S1 = 2'b01,   // seen "1"
        S2 = 2'b10,   // seen "10"
        S3 = 2'b11    // seen "100"
    } state_t;

    localparam logic [3:0] SEQ       = 4'b1001;
    localparam int         CNT_W_DEF = 8;

endpackage

// File: rtl/mealy_1001_overlapping_if.sv
// Serial bit in, combinational match flag out; det_cnt exists only with MEALY_DET_CNT_EN.
interface mealy_1001_overlapping_if #(
    parameter int CNT_W = mealy_1001_pkg::CNT_W_DEF
);
    logic n;
    logic d;
`ifdef MEALY_DET_CNT_EN
    logic [CNT_W-1:0] det_cnt;

    modport master (output n, input  d, input  det_cnt);
    modport slave  (input  n, output d, output det_cnt);
`else
    modport master (output n, input  d);
    modport slave  (input  n, output d);
`endif
endinterface

// File: rtl/mealy_1001_overlapping.sv
// Overlapping "1001" Mealy detector; optional saturating match counter under MEALY_DET_CNT_EN.
// Latency: d is combinational from state and n (zero cycles); det_cnt updates one edge after d.
// Backpressure: none, one bit accepted every clk.
module mealy_1001_overlapping
    import mealy_1001_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    mealy_1001_overlapping_if.slave bus
);

    state_t r_state;
    state_t w_next;
    logic   w_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S0;
        case (r_state)
            S0:      w_next = bus.n ? S1 : S0;
            S1:      w_next = bus.n ? S1 : S2;
            S2:      w_next = bus.n ? S1 : S3;
            // final '1' of a match doubles as the first '1' of the next one
            S3:      w_next = bus.n ? S1 : S0;
            default: w_next = S0;
        endcase
    end

    assign w_d   = rst & (r_state == S3) & bus.n;
    assign bus.d = w_d;

`ifdef MEALY_DET_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_d && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.det_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_mealy_1001_overlapping.sv
// Directed bench for the overlapping "1001" detector; counter checks run with MEALY_DET_CNT_EN.
module tb_mealy_1001_overlapping;
    import mealy_1001_pkg::*;

`ifdef MEALY_DET_CNT_EN
    localparam int TB_CNT_W = 2;
`else
    localparam int TB_CNT_W = 8;
`endif

    logic clk = 1'b0;
    logic rst;
    int   tests    = 0;
    int   failures = 0;

    mealy_1001_overlapping_if #(.CNT_W(TB_CNT_W)) bus ();

    mealy_1001_overlapping #(.CNT_W(TB_CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input logic [7:0] obs, input logic [7:0] exp, input string tag);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one bit with reset released and check d before the capturing edge.
    task automatic step(input logic nv, input logic ev, input string tag);
        @(negedge clk);
        rst   = 1'b1;
        bus.n = nv;
        #1;
        check({7'd0, bus.d}, {7'd0, ev}, tag);
    endtask

    // One reset cycle with n=1; d must stay low whatever the state.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst   = 1'b0;
        bus.n = 1'b1;
        #1;
        check({7'd0, bus.d}, 8'd0, tag);
        @(posedge clk);
        #1;
        check({6'd0, dut.r_state}, {6'd0, S0}, {tag, "_state"});
    endtask

    task automatic check_state_after_edge(input state_t exp, input string tag);
        @(posedge clk);
        #1;
        check({6'd0, dut.r_state}, {6'd0, exp}, tag);
    endtask

    logic [6:0]  ov_n, ov_d, nm_n, nm_d;
    logic [7:0]  bb_n, bb_d;
    logic [3:0]  nm2_n;

    initial begin
        rst   = 1'b0;
        bus.n = 1'b1;
        #1;
        check({7'd0, bus.d}, 8'd0, "pre_reset_d");
        @(posedge clk);
        #1;
        check({6'd0, dut.r_state}, {6'd0, S0}, "reset_state");

        // basic match, MSB of SEQ first
        for (int i = 3; i >= 0; i--) step(SEQ[i], (i == 0), $sformatf("basic_b%0d", 3 - i));
        check_state_after_edge(S1, "basic_state_s1");
        check({7'd0, bus.d}, 8'd0, "basic_d_fall");

        do_reset("rst_ov");
        ov_n = 7'b1001001; ov_d = 7'b0001001;
        for (int i = 6; i >= 0; i--) step(ov_n[i], ov_d[i], $sformatf("overlap_b%0d", 6 - i));

        do_reset("rst_nm1");
        nm_n = 7'b1010001; nm_d = 7'b0000000;
        for (int i = 6; i >= 0; i--) step(nm_n[i], nm_d[i], $sformatf("near1_b%0d", 6 - i));

        do_reset("rst_nm2");
        nm2_n = 4'b1101;
        for (int i = 3; i >= 0; i--) step(nm2_n[i], 1'b0, $sformatf("near2_b%0d", 3 - i));

        do_reset("rst_bb");
        bb_n = 8'b10011001; bb_d = 8'b00010001;
        for (int i = 7; i >= 0; i--) step(bb_n[i], bb_d[i], $sformatf("b2b_b%0d", 7 - i));

        // mid-sequence reset while sitting in S3 with n=1
        do_reset("rst_mid");
        step(1'b1, 1'b0, "mid_b0");
        step(1'b0, 1'b0, "mid_b1");
        step(1'b0, 1'b0, "mid_b2");
        do_reset("mid_reset_forced_d");
        step(1'b1, 1'b0, "mid_after_reset");
        check_state_after_edge(S1, "mid_state_s1");

        // d follows n combinationally inside the cycle
        do_reset("rst_drop");
        step(1'b1, 1'b0, "drop_b0");
        step(1'b0, 1'b0, "drop_b1");
        step(1'b0, 1'b0, "drop_b2");
        @(negedge clk);
        bus.n = 1'b1;
        #1;
        check({7'd0, bus.d}, 8'd1, "drop_d_rise");
        bus.n = 1'b0;
        #1;
        check({7'd0, bus.d}, 8'd0, "drop_d_fall");
        check_state_after_edge(S0, "drop_state_s0");

`ifdef MEALY_DET_CNT_EN
        do_reset("rst_cnt");
        check({6'd0, bus.det_cnt}, 8'd0, "cnt_reset");
        step(1'b1, 1'b0, "cnt_lead");
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b0, $sformatf("cnt_m%0d_b1", k));
            step(1'b0, 1'b0, $sformatf("cnt_m%0d_b2", k));
            step(1'b1, 1'b1, $sformatf("cnt_m%0d_b3", k));
            @(posedge clk);
            #1;
            check({6'd0, bus.det_cnt}, (k > 3) ? 8'd3 : 8'(k), $sformatf("cnt_after_m%0d", k));
        end
        do_reset("rst_cnt2");
        check({6'd0, bus.det_cnt}, 8'd0, "cnt_cleared");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
